// File: rtl/xdma_rr_prio_arbiter.sv
// Registered N-way arbiter with valid/ready handshake; fixed MSB-first or round-robin
// priority, grant held stable until the consumer accepts it.
module xdma_rr_prio_arbiter #(
  parameter int N     = 4,
  parameter int IDX_W = (N > 1) ? $clog2(N) : 1
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic [N-1:0]     req_i,
  input  logic             mode_i,
  output logic             valid_o,
  input  logic             ready_i,
  output logic [IDX_W-1:0] idx_o,
  output logic [N-1:0]     gnt_o
);

  localparam logic [0:0]       ST_IDLE  = 1'b0;
  localparam logic [0:0]       ST_GRANT = 1'b1;
  localparam logic [IDX_W-1:0] TOP_IDX  = IDX_W'(N - 1);

  logic [0:0]       state_q, state_d;
  logic [IDX_W-1:0] idx_q, idx_d;
  logic [IDX_W-1:0] ptr_q, ptr_d;
  logic [N-1:0]     gnt_q, gnt_d;
  logic [IDX_W-1:0] start_idx;
  logic [IDX_W-1:0] win_idx;
  logic             handshake;

  assign handshake = (state_q == ST_GRANT) && ready_i;

  always_comb begin
    ptr_d = ptr_q;
    if (handshake && mode_i) begin
      ptr_d = (idx_q == '0) ? TOP_IDX : idx_q - IDX_W'(1);
    end
  end

  // Back-to-back rearbitration must see the pointer as updated by this handshake.
  assign start_idx = mode_i ? ptr_d : TOP_IDX;

  always_comb begin : scan
    int  pos;
    logic found;
    win_idx = '0;
    found   = 1'b0;
    for (int k = 0; k < N; k++) begin
      pos = int'(start_idx) - k;
      if (pos < 0) pos = pos + N;
      if (!found && req_i[IDX_W'(pos)]) begin
        win_idx = IDX_W'(pos);
        found   = 1'b1;
      end
    end
  end

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    gnt_d   = gnt_q;
    case (state_q)
      ST_IDLE: begin
        if (|req_i) begin
          state_d = ST_GRANT;
          idx_d   = win_idx;
          gnt_d   = N'(1) << win_idx;
        end
      end
      ST_GRANT: begin
        if (ready_i) begin
          if (|req_i) begin
            idx_d = win_idx;
            gnt_d = N'(1) << win_idx;
          end else begin
            state_d = ST_IDLE;
            gnt_d   = '0;
          end
        end
      end
      default: begin
        state_d = ST_IDLE;
        gnt_d   = '0;
      end
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= ST_IDLE;
      idx_q   <= '0;
      ptr_q   <= TOP_IDX;
      gnt_q   <= '0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      ptr_q   <= ptr_d;
      gnt_q   <= gnt_d;
    end
  end

  assign valid_o = (state_q == ST_GRANT);
  assign idx_o   = idx_q;
  assign gnt_o   = gnt_q;

  a_gnt_onehot0: assert property (@(posedge clk_i) $onehot0(gnt_o));
  a_grant_locked: assert property (@(posedge clk_i) disable iff (rst_i)
    (valid_o && !ready_i) |=> (valid_o && $stable(idx_o)));

endmodule

// File: tb/tb_xdma_rr_prio_arbiter.sv
// Directed plus randomized bench for xdma_rr_prio_arbiter (N=4), checked against a
// behavioural model of the arbitration rules.
module tb_xdma_rr_prio_arbiter;

  localparam int N = 4;

  logic       clk_i = 1'b0;
  logic       rst_i;
  logic [3:0] req_i;
  logic       mode_i;
  logic       valid_o;
  logic       ready_i;
  logic [1:0] idx_o;
  logic [3:0] gnt_o;

  int n_vec  = 0;
  int n_fail = 0;

  // model state
  bit m_valid;
  int m_idx;
  int m_ptr;

  xdma_rr_prio_arbiter #(.N(N)) dut (
    .clk_i  (clk_i),
    .rst_i  (rst_i),
    .req_i  (req_i),
    .mode_i (mode_i),
    .valid_o(valid_o),
    .ready_i(ready_i),
    .idx_o  (idx_o),
    .gnt_o  (gnt_o)
  );

  always #5 clk_i = ~clk_i;

  task automatic check_eq(input string tag, input int obs, input int exp);
    n_vec++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  // Priority order is start, start-1, ..., wrapping; the first requester in that order wins.
  function automatic int win(input logic [3:0] r, input int start);
    int order[N];
    for (int rank = 0; rank < N; rank++) order[rank] = (start - rank + N) % N;
    foreach (order[j]) if (r[order[j]]) return order[j];
    return 0;
  endfunction

  task automatic model_step();
    if (rst_i) begin
      m_valid = 0; m_idx = 0; m_ptr = N - 1;
    end else if (!m_valid) begin
      if (req_i != 0) begin
        m_idx   = win(req_i, mode_i ? m_ptr : N - 1);
        m_valid = 1;
      end
    end else if (ready_i) begin
      if (mode_i) m_ptr = (m_idx + N - 1) % N;
      if (req_i != 0) m_idx = win(req_i, mode_i ? m_ptr : N - 1);
      else m_valid = 0;
    end
  endtask

  // One clock: model consumes the inputs seen at the edge, outputs checked 1 time unit later.
  task automatic step();
    bit was_rst;
    was_rst = rst_i;
    @(posedge clk_i);
    model_step();
    #1;
    check_eq("valid", int'(valid_o), int'(m_valid));
    check_eq("gnt", int'(gnt_o), m_valid ? (1 << m_idx) : 0);
    if (m_valid || was_rst) check_eq("idx", int'(idx_o), m_idx);
  endtask

  task automatic drive(input logic r, input logic [3:0] q, input logic m, input logic rdy);
    rst_i = r; req_i = q; mode_i = m; ready_i = rdy;
  endtask

  initial begin
    int rr_seq[6] = '{3, 2, 1, 0, 3, 2};
    m_valid = 0; m_idx = 0; m_ptr = N - 1;

    // reset held with all requests active
    drive(1'b1, 4'b1111, 1'b0, 1'b1);
    step();
    step();
    check_eq("rst_idx", int'(idx_o), 0);
    drive(1'b0, 4'b1111, 1'b0, 1'b1);
    step();
    check_eq("first_grant", int'(idx_o), 3);

    // fixed priority
    drive(1'b0, 4'b1011, 1'b0, 1'b1);
    repeat (3) begin
      step();
      check_eq("fixed_1011", int'(idx_o), 3);
      check_eq("fixed_gnt", int'(gnt_o), 8);
    end
    req_i = 4'b0011;
    step();
    check_eq("fixed_0011", int'(idx_o), 1);
    req_i = 4'b0000;
    step();
    check_eq("to_idle", int'(valid_o), 0);

    // round-robin fairness, no bubbles
    drive(1'b0, 4'b1111, 1'b1, 1'b1);
    foreach (rr_seq[i]) begin
      step();
      check_eq("rr_seq", int'(idx_o), rr_seq[i]);
      check_eq("rr_valid", int'(valid_o), 1);
    end

    // backpressure lock
    drive(1'b0, 4'b0000, 1'b1, 1'b1);
    step();
    drive(1'b0, 4'b1111, 1'b0, 1'b1);
    step();
    check_eq("lock_start", int'(idx_o), 3);
    drive(1'b0, 4'b0001, 1'b0, 1'b0);
    repeat (5) begin
      step();
      check_eq("lock_idx", int'(idx_o), 3);
      check_eq("lock_gnt", int'(gnt_o), 8);
    end
    ready_i = 1'b1;
    step();
    check_eq("after_lock", int'(idx_o), 0);
    req_i = 4'b0000;
    step();
    check_eq("lock_idle", int'(valid_o), 0);

    // wrap and sparse round-robin
    drive(1'b0, 4'b1011, 1'b1, 1'b1);
    step();
    check_eq("sparse_1", int'(idx_o), 1);
    step();
    check_eq("sparse_0", int'(idx_o), 0);
    step();
    check_eq("sparse_3", int'(idx_o), 3);
    req_i = 4'b0100;
    step();
    check_eq("single_2", int'(idx_o), 2);
    step();
    check_eq("single_2_again", int'(idx_o), 2);

    // reset while granting in round-robin
    req_i = 4'b0010;
    step();
    check_eq("pre_rst_idx", int'(idx_o), 1);
    drive(1'b1, 4'b1111, 1'b1, 1'b1);
    step();
    check_eq("mid_rst_valid", int'(valid_o), 0);
    drive(1'b0, 4'b1111, 1'b1, 1'b1);
    step();
    check_eq("post_rst_idx", int'(idx_o), 3);

    // randomized traffic
    for (int i = 0; i < 400; i++) begin
      req_i   = 4'($urandom_range(0, 15));
      mode_i  = ($urandom_range(0, 9) < 2) ? ~mode_i : mode_i;
      ready_i = ($urandom_range(0, 3) != 0);
      rst_i   = ($urandom_range(0, 99) == 0);
      if (rst_i) ready_i = 1'b1;
      step();
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end

endmodule
